// File: rtl/ipg_reply_queue.sv
// Reply-chunk FIFO between the memory side and PHY TX. Whole messages are released
// once their last chunk is stored; an oversize message that fills the FIFO is cut through.
module ipg_reply_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    reply_data,
    input  logic                     reply_last,
    input  logic                     reply_valid,
    output logic                     reply_ready,
    input  logic                     tx_pause,
    output logic [DATA_WIDTH-1:0]    ipg_reply_chunk,
    output logic                     memq_write,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [$clog2(DEPTH):0]   msg_count,
    output logic                     dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       msg_q, msg_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic [DATA_WIDTH:0] head;
    logic                head_last;
    logic                push;
    logic                pop;
    logic [LW-1:0]       level;

    // Pointers carry a wrap bit, so their difference is the level (0..DEPTH).
    assign level       = wr_ptr_q - rd_ptr_q;
    assign fifo_level  = level;
    assign msg_count   = msg_q;
    assign reply_ready = (level != FULL_LVL);
    assign push        = reply_valid && reply_ready;

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign head_last   = head[DATA_WIDTH];
    assign memq_write  = (state_q == SEND) && !tx_pause && (level != '0);
    assign pop         = memq_write;
    assign ipg_reply_chunk = memq_write ? head[DATA_WIDTH-1:0] : '0;
    assign dbg_state_o = (state_q == SEND);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        msg_d    = msg_q;
        if (push) wr_ptr_d = wr_ptr_q + LW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);
        case ({push && reply_last, pop && head_last})
            2'b10:   msg_d = msg_q + LW'(1);
            2'b01:   msg_d = msg_q - LW'(1);
            default: msg_d = msg_q;
        endcase
        case (state_q)
            // A full FIFO with no complete message can only drain by cutting through.
            IDLE:    if (msg_q != '0 || level == FULL_LVL) state_d = SEND;
            SEND:    if (pop && head_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            msg_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            msg_q    <= msg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {reply_last, reply_data};
    end

endmodule

// File: tb/tb_ipg_reply_queue.sv
// Scoreboarded bench for ipg_reply_queue: directed message scenarios, ordering,
// latency, pause, full/cut-through, simultaneous push/pop and mid-send reset.
module tb_ipg_reply_queue;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] reply_data;
    logic          reply_last;
    logic          reply_valid;
    logic          reply_ready;
    logic          tx_pause;
    logic [DW-1:0] ipg_reply_chunk;
    logic          memq_write;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] msg_count;
    logic          dbg_state_o;

    ipg_reply_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reply_data      (reply_data),
        .reply_last      (reply_last),
        .reply_valid     (reply_valid),
        .reply_ready     (reply_ready),
        .tx_pause        (tx_pause),
        .ipg_reply_chunk (ipg_reply_chunk),
        .memq_write      (memq_write),
        .fifo_level      (fifo_level),
        .msg_count       (msg_count),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0;
    int first_wr = -1;
    int last_acc = 0;
    int wr_cycs[$];
    int msg_peak = 0;
    bit saw_not_ready = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every delivered chunk is popped from the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memq_write) begin
                n_wr++;
                wr_cycs.push_back(cyc);
                if (first_wr < 0) first_wr = cyc;
                if (exp_q.size() == 0) check("extra_chunk", 64'(memq_write), 64'(0));
                else check("chunk", ipg_reply_chunk, exp_q.pop_front());
            end else begin
                check("idle_zero", ipg_reply_chunk, 64'(0));
            end
            if (tx_pause) check("pause_hold", 64'(memq_write), 64'(0));
            if (int'(msg_count) > msg_peak) msg_peak = int'(msg_count);
            if (!reply_ready) begin
                saw_not_ready = 1'b1;
                check("full_level", 64'(fifo_level), 64'(DEPTH));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        int tries = 0;
        bit done = 1'b0;
        reply_data  = d;
        reply_last  = l;
        reply_valid = 1'b1;
        while (!done && tries < 100) begin
            @(negedge clk);
            if (reply_ready) begin
                exp_q.push_back(d);
                last_acc = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
        end
        reply_valid = 1'b0;
        reply_last  = 1'b0;
        reply_data  = '0;
        if (!done) check("push_timeout", 64'(reply_ready), 64'(1));
    endtask

    task automatic wait_writes(input int target);
        int t = 0;
        while (n_wr < target && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("write_wait", 64'(n_wr >= target), 64'(1));
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (!(exp_q.size() == 0 && fifo_level == '0 && !dbg_state_o) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_lvl"}, 64'(fifo_level), 64'(0));
        check({tag, "_msg"}, 64'(msg_count), 64'(0));
    endtask

    task automatic new_test();
        first_wr = -1;
        wr_cycs.delete();
        msg_peak = 0;
        saw_not_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_before;
        rst_n       = 1'b0;
        reply_data  = '0;
        reply_last  = 1'b0;
        reply_valid = 1'b0;
        tx_pause    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(reply_ready), 64'(1));
        check("rst_write", 64'(memq_write), 64'(0));
        check("rst_chunk", ipg_reply_chunk, 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_msg", 64'(msg_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 3-chunk message: first write two cycles after the last is accepted.
        new_test();
        push_beat(64'hA1, 1'b0);
        push_beat(64'hA2, 1'b0);
        push_beat(64'hA3, 1'b1);
        wait_drain("t1");
        check("t1_latency", 64'(first_wr), 64'(last_acc + 2));
        check("t1_count", 64'(wr_cycs.size()), 64'(3));
        if (wr_cycs.size() == 3) check("t1_burst", 64'(wr_cycs[2] - wr_cycs[0]), 64'(2));
        check("t1_peak", 64'(msg_peak), 64'(1));

        // Two-cycle pause right after the first chunk.
        new_test();
        push_beat(64'hB1, 1'b0);
        push_beat(64'hB2, 1'b0);
        push_beat(64'hB3, 1'b1);
        wait_writes(n_wr + 1);
        tx_pause = 1'b1;
        idle_cycles(2);
        tx_pause = 1'b0;
        wait_drain("t2");
        check("t2_count", 64'(wr_cycs.size()), 64'(3));
        if (wr_cycs.size() == 3) begin
            check("t2_gap", 64'(wr_cycs[1] - wr_cycs[0]), 64'(3));
            check("t2_tail", 64'(wr_cycs[2] - wr_cycs[1]), 64'(1));
        end

        // Back-to-back 2-chunk messages: one idle cycle between them.
        new_test();
        push_beat(64'hC1, 1'b0);
        push_beat(64'hC2, 1'b1);
        push_beat(64'hD1, 1'b0);
        push_beat(64'hD2, 1'b1);
        wait_drain("t3");
        check("t3_peak", 64'(msg_peak), 64'(2));
        check("t3_count", 64'(wr_cycs.size()), 64'(4));
        if (wr_cycs.size() == 4) begin
            check("t3_m1", 64'(wr_cycs[1] - wr_cycs[0]), 64'(1));
            check("t3_gap", 64'(wr_cycs[2] - wr_cycs[1]), 64'(2));
            check("t3_m2", 64'(wr_cycs[3] - wr_cycs[2]), 64'(1));
        end

        // Last of message 2 pushed in the cycle message 1's last pops.
        new_test();
        push_beat(64'hE1, 1'b0);
        push_beat(64'hE2, 1'b1);
        idle_cycles(1);
        push_beat(64'hF1, 1'b0);
        reply_data  = 64'hF2;
        reply_last  = 1'b1;
        reply_valid = 1'b1;
        @(negedge clk);
        check("t4_pop", 64'(memq_write), 64'(1));
        check("t4_ready", 64'(reply_ready), 64'(1));
        check("t4_lvl_pre", 64'(fifo_level), 64'(2));
        check("t4_msg_pre", 64'(msg_count), 64'(1));
        if (reply_ready) exp_q.push_back(64'hF2);
        @(posedge clk);
        #1;
        reply_valid = 1'b0;
        reply_last  = 1'b0;
        reply_data  = '0;
        @(negedge clk);
        check("t4_lvl_post", 64'(fifo_level), 64'(2));
        check("t4_msg_post", 64'(msg_count), 64'(1));
        @(posedge clk);
        #1;
        wait_drain("t4");

        // Oversize 20-chunk message fills the FIFO and is cut through.
        new_test();
        for (int i = 0; i < 20; i++) push_beat(64'h5000 + 64'(i), (i == 19));
        check("t5_full_seen", 64'(saw_not_ready), 64'(1));
        wait_drain("t5");
        check("t5_count", 64'(wr_cycs.size()), 64'(20));

        // Reset after the first of three chunks has gone out.
        new_test();
        push_beat(64'h71, 1'b0);
        push_beat(64'h72, 1'b0);
        push_beat(64'h73, 1'b1);
        wait_writes(n_wr + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_write", 64'(memq_write), 64'(0));
        check("t6_chunk", ipg_reply_chunk, 64'(0));
        check("t6_ready", 64'(reply_ready), 64'(1));
        check("t6_level", 64'(fifo_level), 64'(0));
        check("t6_msg", 64'(msg_count), 64'(0));
        exp_q.delete();
        n_before = n_wr;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(8);
        check("t6_no_more", 64'(n_wr), 64'(n_before));
        check("t6_level_after", 64'(fifo_level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
